// File: rtl/branch_trace_compressor.sv
// rtl/branch_trace_compressor.sv - retire stream to discontinuity packets, 2-entry output FIFO
module branch_trace_compressor #(
  parameter int          XLEN      = 64,
  parameter int unsigned MAX_RUN   = 1024,
  parameter int          PKT_WIDTH = XLEN + 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [31:0]          instr,
  input  logic [XLEN-1:0]      pc,
  input  logic                 pc_valid,
  output logic                 pkt_valid,
  input  logic                 pkt_ready,
  output logic [PKT_WIDTH-1:0] pkt_data,
  output logic [31:0]          dropped_count,
  output logic                 overflow
);

  localparam logic [31:0] MAX_RUN_L = 32'(MAX_RUN);

  logic                 first;
  logic [XLEN-1:0]      expected_pc;
  logic [31:0]          run;
  logic [PKT_WIDTH-1:0] entry0, entry1;
  logic [1:0]           count;

  logic                 retire;
  logic [XLEN-1:0]      step;
  logic                 emit;
  logic [PKT_WIDTH-1:0] emit_data;
  logic [31:0]          run_next;
  logic                 pop, push, drop;

  assign retire = enable & pc_valid;
  assign step   = (instr[1:0] == 2'b11) ? XLEN'(4) : XLEN'(2);

  always_comb begin
    emit      = 1'b0;
    emit_data = '0;
    run_next  = run;
    if (retire) begin
      if (first) begin
        emit      = 1'b1;
        emit_data = {pc, 32'd0};
        run_next  = 32'd1;
      end else if (pc != expected_pc) begin
        emit      = 1'b1;
        emit_data = {pc, run};
        run_next  = 32'd1;
      end else if (run == MAX_RUN_L) begin
        emit      = 1'b1;
        emit_data = {pc, MAX_RUN_L};
        run_next  = 32'd1;
      end else begin
        run_next  = run + 32'd1;
      end
    end
  end

  // A full FIFO still accepts a push when its head leaves on the same edge.
  assign pop  = (count != 2'd0) & pkt_ready;
  assign push = emit & ((count != 2'd2) | pop);
  assign drop = emit & ~push;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first         <= 1'b1;
      expected_pc   <= '0;
      run           <= '0;
      entry0        <= '0;
      entry1        <= '0;
      count         <= 2'd0;
      dropped_count <= '0;
      overflow      <= 1'b0;
    end else begin
      if (!enable) begin
        first <= 1'b1;
      end else if (retire) begin
        first       <= 1'b0;
        run         <= run_next;
        expected_pc <= pc + step;
      end

      case ({push, pop})
        2'b11: begin
          if (count == 2'd1) begin
            entry0 <= emit_data;
          end else begin
            entry0 <= entry1;
            entry1 <= emit_data;
          end
        end
        2'b10: begin
          if (count == 2'd0) entry0 <= emit_data;
          else               entry1 <= emit_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        default: ;
      endcase

      if (drop) begin
        overflow <= 1'b1;
        if (dropped_count != 32'hFFFF_FFFF) dropped_count <= dropped_count + 32'd1;
      end
    end
  end

  assign pkt_valid = (count != 2'd0);
  assign pkt_data  = entry0;

endmodule

// File: tb/tb_branch_trace_compressor.sv
// tb/tb_branch_trace_compressor.sv - directed table-driven bench for branch_trace_compressor
module tb_branch_trace_compressor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        pc_valid;
  logic        pkt_ready;

  logic        pkt_valid, pkt_valid4;
  logic [95:0] pkt_data, pkt_data4;
  logic [31:0] dropped_count, dropped_count4;
  logic        overflow, overflow4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_trace_compressor dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .instr(instr), .pc(pc), .pc_valid(pc_valid),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
    .dropped_count(dropped_count), .overflow(overflow)
  );

  branch_trace_compressor #(.MAX_RUN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .instr(instr), .pc(pc), .pc_valid(pc_valid),
    .pkt_valid(pkt_valid4), .pkt_ready(pkt_ready), .pkt_data(pkt_data4),
    .dropped_count(dropped_count4), .overflow(overflow4)
  );

  typedef struct {
    logic        en;
    logic        pv;
    logic        rdy;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        ev;
    logic [95:0] ed;
    logic [31:0] edc;
    logic        eovf;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] I32 = 32'h0000_0013;
  localparam logic [31:0] I16 = 32'h0000_0001;

  function automatic logic [95:0] pk(input logic [63:0] p, input logic [31:0] r);
    return {p, r};
  endfunction

  task automatic add(input logic en, input logic pv, input logic rdy, input logic [63:0] p,
                     input logic [31:0] ins, input logic ev, input logic [95:0] ed,
                     input logic [31:0] edc, input logic eovf);
    vec_t v;
    v.en = en; v.pv = pv; v.rdy = rdy; v.pc = p; v.instr = ins;
    v.ev = ev; v.ed = ed; v.edc = edc; v.eovf = eovf;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic pv, input logic rdy,
                       input logic [63:0] p, input logic [31:0] ins);
    enable = en; pc_valid = pv; pkt_ready = rdy; pc = p; instr = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; pc_valid = 1'b0; pkt_ready = 1'b0; pc = '0; instr = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("reset_valid", 96'(pkt_valid), 96'(0));
    chk("reset_data", pkt_data, 96'(0));
    chk("reset_drop", 96'(dropped_count), 96'(0));
    chk("reset_ovf", 96'(overflow), 96'(0));

    // en pv rdy pc instr | exp_valid exp_data exp_dropped exp_overflow
    add(1, 1, 1, 64'h1000, I32, 1, pk(64'h1000, 0), 0, 0);
    add(1, 1, 1, 64'h1004, I32, 0, '0, 0, 0);
    add(1, 1, 1, 64'h1008, I32, 0, '0, 0, 0);
    add(1, 1, 1, 64'h100C, I32, 0, '0, 0, 0);
    add(1, 1, 1, 64'h1010, I32, 0, '0, 0, 0);
    add(1, 1, 1, 64'h2000, I32, 1, pk(64'h2000, 5), 0, 0);
    add(1, 1, 1, 64'h1000, I16, 1, pk(64'h1000, 1), 0, 0);
    add(1, 1, 1, 64'h1002, I32, 0, '0, 0, 0);
    add(1, 1, 1, 64'h1006, I32, 0, '0, 0, 0);
    add(1, 1, 0, 64'h3000, I32, 1, pk(64'h3000, 3), 0, 0);
    add(1, 1, 0, 64'h4000, I32, 1, pk(64'h3000, 3), 0, 0);
    add(1, 1, 0, 64'h5000, I32, 1, pk(64'h3000, 3), 1, 1);
    add(1, 1, 0, 64'h6000, I32, 1, pk(64'h3000, 3), 2, 1);
    add(1, 0, 1, 64'h0,    I32, 1, pk(64'h4000, 1), 2, 1);
    add(1, 0, 1, 64'h0,    I32, 0, '0, 2, 1);
    add(1, 1, 0, 64'h7000, I32, 1, pk(64'h7000, 1), 2, 1);
    add(1, 1, 0, 64'h8000, I32, 1, pk(64'h7000, 1), 2, 1);
    add(1, 1, 1, 64'h9000, I32, 1, pk(64'h8000, 1), 2, 1);
    add(1, 0, 1, 64'h0,    I32, 1, pk(64'h9000, 1), 2, 1);
    add(1, 0, 1, 64'h0,    I32, 0, '0, 2, 1);
    add(0, 1, 1, 64'h9004, I32, 0, '0, 2, 1);
    add(1, 1, 1, 64'h9004, I32, 1, pk(64'h9004, 0), 2, 1);
    add(1, 0, 1, 64'h0,    I32, 0, '0, 2, 1);
    add(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, I32, 1, pk(64'hFFFF_FFFF_FFFF_FFFC, 1), 2, 1);
    add(1, 1, 1, 64'h0,    I32, 0, '0, 2, 1);
    add(1, 0, 1, 64'h0,    I32, 0, '0, 2, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].pv, vecs[i].rdy, vecs[i].pc, vecs[i].instr);
      chk($sformatf("v%0d_valid", i), 96'(pkt_valid), 96'(vecs[i].ev));
      if (vecs[i].ev) chk($sformatf("v%0d_data", i), pkt_data, vecs[i].ed);
      chk($sformatf("v%0d_dropped", i), 96'(dropped_count), 96'(vecs[i].edc));
      chk($sformatf("v%0d_overflow", i), 96'(overflow), 96'(vecs[i].eovf));
    end

    // Forced packets every MAX_RUN sequential retires on the MAX_RUN=4 instance.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      logic exp_v;
      logic [95:0] exp_d;
      drive(1, 1, 1, 64'(4 * i), I32);
      exp_v = (i == 0) || (i == 4) || (i == 8);
      exp_d = (i == 0) ? pk(64'h0, 0) : pk(64'(4 * i), 4);
      chk($sformatf("maxrun%0d_valid", i), 96'(pkt_valid4), 96'(exp_v));
      if (exp_v) chk($sformatf("maxrun%0d_data", i), pkt_data4, exp_d);
    end
    drive(1, 1, 1, 64'h1000, I32);
    chk("maxrun_tail_valid", 96'(pkt_valid4), 96'(1));
    chk("maxrun_tail_data", pkt_data4, pk(64'h1000, 2));
    chk("maxrun_no_drop", 96'(dropped_count4), 96'(0));

    // Reset while two entries are pending.
    do_reset();
    drive(1, 1, 0, 64'h100, I32);
    drive(1, 1, 0, 64'h200, I32);
    chk("mid_pending_head", pkt_data, pk(64'h100, 0));
    enable = 1'b1; pc_valid = 1'b1; pc = 64'h300; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_reset_valid", 96'(pkt_valid), 96'(0));
    chk("mid_reset_data", pkt_data, 96'(0));
    drive(1, 1, 1, 64'h0, I32);
    chk("post_reset_emit_valid", 96'(pkt_valid), 96'(1));
    chk("post_reset_emit_data", pkt_data, pk(64'h0, 0));
    drive(1, 0, 1, 64'h0, I32);
    chk("post_reset_drained", 96'(pkt_valid), 96'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
